// File: rtl/joint_step_generator.sv
// Two-axis step/dir pulse generator fed by the inverse-kinematics angle stage.
// Latches signed joint targets on enable, derives per-joint step counts and
// directions from the tracked positions, then issues concurrent step trains.
// Handshake: enable is a single-cycle request honoured only while busy=0;
// a request seen while busy=1 is dropped (no queue). done pulses for exactly
// one cycle at the end of every accepted request, including zero-length moves.
module joint_step_generator #(
    parameter int unsigned PULSE_HIGH = 50,
    parameter int unsigned PULSE_LOW  = 50,
    parameter int unsigned DIR_SETUP  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic signed [12:0] th1,
    input  logic signed [12:0] th2,
    input  logic               stop,
    input  logic               home,
    output logic               busy,
    output logic               done,
    output logic               step1,
    output logic               dir1,
    output logic               step2,
    output logic               dir2,
    output logic signed [12:0] pos1,
    output logic signed [12:0] pos2
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_SETUP     = 3'd2;
    localparam logic [2:0] S_STEP_HIGH = 3'd3;
    localparam logic [2:0] S_STEP_LOW  = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]         state;
    logic [31:0]        cnt;
    logic signed [12:0] tgt1;
    logic signed [12:0] tgt2;
    logic [12:0]        rem1;
    logic [12:0]        rem2;
    logic               stop_latch;
    logic               stop_now;
    logic signed [13:0] delta1;
    logic signed [13:0] delta2;
    logic [12:0]        abs1;
    logic [12:0]        abs2;

    // Outputs decode straight from state so a reset clears them on the next edge.
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign step1    = (state == S_STEP_HIGH) && (rem1 != 13'd0);
    assign step2    = (state == S_STEP_HIGH) && (rem2 != 13'd0);
    // A stop arriving on a decision cycle counts immediately, not one cycle late.
    assign stop_now = stop_latch | stop;

    // Signed distance to target at 14 bits so a full-range move cannot overflow.
    always_comb begin
        delta1 = {tgt1[12], tgt1} - {pos1[12], pos1};
        delta2 = {tgt2[12], tgt2} - {pos2[12], pos2};
        abs1   = delta1[13] ? 13'(-delta1) : 13'(delta1);
        abs2   = delta2[13] ? 13'(-delta2) : 13'(delta2);
    end

    // Sticky abort request: armed in any busy state, released when the move retires.
    always_ff @(posedge clk) begin
        if (reset) begin
            stop_latch <= 1'b0;
        end else if (state == S_DONE) begin
            stop_latch <= 1'b0;
        end else if (state != S_IDLE && stop) begin
            stop_latch <= 1'b1;
        end
    end

    // Move sequencer: load, direction setup, then alternating high/low phases.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 32'd0;
            tgt1  <= 13'sd0;
            tgt2  <= 13'sd0;
            rem1  <= 13'd0;
            rem2  <= 13'd0;
            dir1  <= 1'b0;
            dir2  <= 1'b0;
            pos1  <= 13'sd0;
            pos2  <= 13'sd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        tgt1  <= th1;
                        tgt2  <= th2;
                        state <= S_LOAD;
                    end else if (home) begin
                        pos1 <= 13'sd0;
                        pos2 <= 13'sd0;
                    end
                end
                S_LOAD: begin
                    rem1 <= abs1;
                    rem2 <= abs2;
                    dir1 <= !delta1[13] && (delta1 != 14'sd0);
                    dir2 <= !delta2[13] && (delta2 != 14'sd0);
                    cnt  <= 32'd0;
                    if (abs1 == 13'd0 && abs2 == 13'd0) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == DIR_SETUP - 1) begin
                        cnt   <= 32'd0;
                        state <= stop_now ? S_DONE : S_STEP_HIGH;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_STEP_HIGH: begin
                    // A pulse that has started is always finished and counted.
                    if (cnt == PULSE_HIGH - 1) begin
                        cnt <= 32'd0;
                        if (rem1 != 13'd0) begin
                            rem1 <= rem1 - 13'd1;
                            pos1 <= dir1 ? pos1 + 13'sd1 : pos1 - 13'sd1;
                        end
                        if (rem2 != 13'd0) begin
                            rem2 <= rem2 - 13'd1;
                            pos2 <= dir2 ? pos2 + 13'sd1 : pos2 - 13'sd1;
                        end
                        state <= S_STEP_LOW;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_STEP_LOW: begin
                    if (cnt == PULSE_LOW - 1) begin
                        cnt <= 32'd0;
                        if (stop_now || (rem1 == 13'd0 && rem2 == 13'd0)) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_STEP_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joint_step_generator.sv
// Bench for joint_step_generator: cycle-indexed arithmetic model of each move
// feeding an expected queue, one per-cycle compare process, and directed
// literal checks for latency, positions and pulse counts.
module tb_joint_step_generator;

    localparam int H   = 2;
    localparam int L   = 2;
    localparam int DS  = 1;
    localparam int PER = H + L;

    logic               clk    = 1'b0;
    logic               reset  = 1'b1;
    logic               enable = 1'b0;
    logic               stop   = 1'b0;
    logic               home   = 1'b0;
    logic signed [12:0] th1    = 13'sd0;
    logic signed [12:0] th2    = 13'sd0;
    logic               busy;
    logic               done;
    logic               step1;
    logic               dir1;
    logic               step2;
    logic               dir2;
    logic signed [12:0] pos1;
    logic signed [12:0] pos2;

    joint_step_generator #(
        .PULSE_HIGH(H),
        .PULSE_LOW (L),
        .DIR_SETUP (DS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .th1   (th1),
        .th2   (th2),
        .stop  (stop),
        .home  (home),
        .busy  (busy),
        .done  (done),
        .step1 (step1),
        .dir1  (dir1),
        .step2 (step2),
        .dir2  (dir2),
        .pos1  (pos1),
        .pos2  (pos2)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int wrap13(int v);
        logic signed [12:0] t;
        t = 13'(v);
        return int'(t);
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // ---------------- behavioural model ----------------
    bit m_active = 1'b0;
    bit m_stopped;
    bit m_d1, m_d2;
    bit m_dir1 = 1'b0;
    bit m_dir2 = 1'b0;
    int m_k, m_end, m_n, m_p;
    int m_r1, m_r2, m_s1, m_s2;
    int m_pos1 = 0;
    int m_pos2 = 0;
    logic [31:0] exp_q[$];

    // Pulses issued when stop is first seen in cycle ks of the move.
    function automatic int pulses_for_stop(int ks);
        if (ks <= DS) return 0;
        return (ks - 1 - DS) / PER + 1;
    endfunction

    // Pulses whose high phase has ended by cycle k of the move.
    function automatic int completed(int k);
        if (k < 1 + DS + H) return 0;
        return imin(m_p, (k - 1 - DS - H) / PER + 1);
    endfunction

    function automatic logic [31:0] expected_vec();
        bit e_busy, e_done, e_s1, e_s2, e_d1, e_d2;
        int e_p1, e_p2, off;
        e_busy = m_active;
        e_done = m_active && (m_k == m_end);
        e_s1 = 1'b0;
        e_s2 = 1'b0;
        e_d1 = m_dir1;
        e_d2 = m_dir2;
        e_p1 = m_pos1;
        e_p2 = m_pos2;
        if (m_active) begin
            if (m_k >= 1) begin
                e_d1 = m_d1;
                e_d2 = m_d2;
            end
            if (m_k >= 1 + DS && m_k < m_end) begin
                off  = m_k - 1 - DS;
                e_s1 = ((off % PER) < H) && ((off / PER) < m_r1);
                e_s2 = ((off % PER) < H) && ((off / PER) < m_r2);
            end
            e_p1 = wrap13(m_s1 + (m_d1 ? 1 : -1) * imin(completed(m_k), m_r1));
            e_p2 = wrap13(m_s2 + (m_d2 ? 1 : -1) * imin(completed(m_k), m_r2));
        end
        return {e_busy, e_done, e_s1, e_d1, e_s2, e_d2, 13'(e_p1), 13'(e_p2)};
    endfunction

    always @(posedge clk) begin : model
        int d1, d2;
        if (reset) begin
            m_active = 1'b0;
            m_pos1   = 0;
            m_pos2   = 0;
            m_dir1   = 1'b0;
            m_dir2   = 1'b0;
        end else if (m_active) begin
            if (m_k == m_end) begin
                m_active = 1'b0;
                m_pos1   = wrap13(m_s1 + (m_d1 ? 1 : -1) * imin(m_p, m_r1));
                m_pos2   = wrap13(m_s2 + (m_d2 ? 1 : -1) * imin(m_p, m_r2));
                m_dir1   = m_d1;
                m_dir2   = m_d2;
            end else begin
                if (stop && !m_stopped) begin
                    m_stopped = 1'b1;
                    m_p   = imin(m_n, pulses_for_stop(m_k));
                    m_end = (m_n == 0) ? 1 : 1 + DS + m_p * PER;
                end
                m_k++;
            end
        end else if (enable) begin
            d1 = int'(th1) - m_pos1;
            d2 = int'(th2) - m_pos2;
            m_d1 = (d1 > 0);
            m_d2 = (d2 > 0);
            m_r1 = (d1 < 0) ? -d1 : d1;
            m_r2 = (d2 < 0) ? -d2 : d2;
            m_s1 = m_pos1;
            m_s2 = m_pos2;
            m_n  = (m_r1 > m_r2) ? m_r1 : m_r2;
            m_p  = m_n;
            m_stopped = 1'b0;
            m_k   = 0;
            m_end = (m_n == 0) ? 1 : 1 + DS + m_n * PER;
            m_active = 1'b1;
        end else if (home) begin
            m_pos1 = 0;
            m_pos2 = 0;
        end
        if (chk_en) exp_q.push_back(expected_vec());
    end

    // ---------------- scoreboard compare (opposite edge) ----------------
    always @(negedge clk) begin : compare
        logic [31:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("busy",  int'(busy),  int'(e[31]));
            check("done",  int'(done),  int'(e[30]));
            check("step1", int'(step1), int'(e[29]));
            check("dir1",  int'(dir1),  int'(e[28]));
            check("step2", int'(step2), int'(e[27]));
            check("dir2",  int'(dir2),  int'(e[26]));
            check("pos1",  int'(pos1),  int'($signed(e[25:13])));
            check("pos2",  int'(pos2),  int'($signed(e[12:0])));
        end
    end

    // ---------------- pulse / done counters ----------------
    int  n_p1 = 0;
    int  n_p2 = 0;
    int  n_done = 0;
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;
    always @(negedge clk) begin
        if (step1 && !prev1) n_p1++;
        if (step2 && !prev2) n_p2++;
        if (done) n_done++;
        prev1 = step1;
        prev2 = step2;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_move(input int t1, input int t2);
        th1    = 13'(t1);
        th2    = 13'(t2);
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    // Returns the move cycle (0 = first cycle after enable is taken) where done is seen.
    task automatic wait_done(input int budget, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = -1;
        for (int c = 0; c < budget && !seen; c++) begin
            if (done) begin
                cyc  = c;
                seen = 1'b1;
            end else begin
                tick();
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (m_active && c < budget) begin
            tick();
            c++;
        end
        check("idle_timeout", int'(m_active), 0);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int cyc, b1, b2, bd, t1, t2, ks;
        reset = 1'b1;
        repeat (3) tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_pos1", int'(pos1), 0);
        check("reset_pos2", int'(pos2), 0);

        // Basic two-joint move
        b1 = n_p1; b2 = n_p2;
        start_move(3, -2);
        wait_done(100, cyc);
        check("t1_latency", cyc, 14);
        check("t1_pos1", int'(pos1), 3);
        check("t1_pos2", int'(pos2), -2);
        check("t1_dir1", int'(dir1), 1);
        check("t1_dir2", int'(dir2), 0);
        tick();
        check("t1_busy_after", int'(busy), 0);
        check("t1_pulses1", n_p1 - b1, 3);
        check("t1_pulses2", n_p2 - b2, 2);

        // Zero move
        b1 = n_p1; b2 = n_p2;
        start_move(3, -2);
        wait_done(10, cyc);
        check("zero_latency", cyc, 1);
        tick();
        check("zero_pulses", (n_p1 - b1) + (n_p2 - b2), 0);

        // Home in idle
        home = 1'b1;
        tick();
        home = 1'b0;
        check("home_pos1", int'(pos1), 0);
        check("home_pos2", int'(pos2), 0);

        // Stop during the second high phase
        b1 = n_p1;
        start_move(5, 0);
        repeat (6) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(100, cyc);
        check("stop_latency", cyc + 7, 10);
        tick();
        check("stop_pos1", int'(pos1), 2);
        check("stop_pulses1", n_p1 - b1, 2);

        // Next move after an abort starts cleanly
        start_move(-1, 1);
        wait_done(100, cyc);
        check("post_stop_latency", cyc, 14);
        tick();
        check("post_stop_pos1", int'(pos1), -1);
        check("post_stop_pos2", int'(pos2), 1);

        // enable has priority over home
        home = 1'b1;
        start_move(4, 1);
        home = 1'b0;
        check("home_en_pos1", int'(pos1), -1);
        wait_done(100, cyc);
        check("home_en_latency", cyc, 22);
        tick();
        check("home_en_pos1_final", int'(pos1), 4);

        home = 1'b1;
        tick();
        home = 1'b0;
        check("home2_pos1", int'(pos1), 0);

        // Reset during a step high phase
        start_move(-4, 0);
        repeat (6) tick();
        check("rst_pre_step1", int'(step1), 1);
        check("rst_pre_pos1", int'(pos1), -1);
        reset = 1'b1;
        tick();
        check("rst_step1", int'(step1), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_pos1", int'(pos1), 0);
        check("rst_dir1", int'(dir1), 0);
        reset = 1'b0;
        tick();

        // enable during a move is dropped
        bd = n_done;
        start_move(2, 1);
        repeat (3) tick();
        th1 = 13'sd7;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_done(100, cyc);
        repeat (12) tick();
        check("ign_en_done_count", n_done - bd, 1);
        check("ign_en_pos1", int'(pos1), 2);
        check("ign_en_pos2", int'(pos2), 1);

        // Randomized moves with optional stop and home
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                home = 1'b1;
                tick();
                home = 1'b0;
            end
            t1 = int'($urandom_range(0, 24)) - 12;
            t2 = int'($urandom_range(0, 24)) - 12;
            home = ($urandom_range(0, 4) == 0);
            start_move(t1, t2);
            home = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                ks = int'($urandom_range(0, 60));
                repeat (ks) tick();
                stop = 1'b1;
                tick();
                stop = 1'b0;
            end
            wait_idle(2000);
        end

        // Full range
        home = 1'b1;
        tick();
        home = 1'b0;
        start_move(-4096, 0);
        wait_done(20000, cyc);
        check("fr1_latency", cyc, 1 + DS + 4096 * PER);
        tick();
        check("fr1_pos1", int'(pos1), -4096);
        b1 = n_p1;
        start_move(4095, 0);
        tick();
        check("fr2_dir1", int'(dir1), 1);
        wait_done(40000, cyc);
        check("fr2_latency", cyc + 1, 1 + DS + 8191 * PER);
        tick();
        check("fr2_pulses1", n_p1 - b1, 8191);
        check("fr2_pos1", int'(pos1), 4095);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
